// File: rtl/ahb_arbiter_rr_if.sv
// ahb_arbiter_rr_if: AHB arbitration bundle (requests, owner transfer status, grant outputs)
interface ahb_arbiter_rr_if #(parameter int N = 4);
   localparam int MW = $clog2(N);
   logic [N-1:0] hbusreq, hlock, hsplit, hgrant;
   logic [1:0] htrans, hresp;
   logic [2:0] hburst;
   logic hready, hmastlock;
   logic [MW-1:0] hmaster;
   modport master (input hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
                   output hgrant, hmaster, hmastlock);
   modport slave (output hbusreq, hlock, htrans, hburst, hready, hresp, hsplit,
                  input hgrant, hmaster, hmastlock);
endinterface

// File: rtl/ahb_arbiter_rr.sv
// ahb_arbiter_rr: round-robin AHB arbiter honouring bursts, locks and SPLIT masking.
// Define AHB_ARB_FIXED_PRIO_EN to pick the lowest-index eligible master instead.
module ahb_arbiter_rr #(
   parameter int NO_OF_MASTERS = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input logic clk,
   input logic rst_n,
   ahb_arbiter_rr_if.master bus
);
   localparam int N = NO_OF_MASTERS;
   localparam int MW = $clog2(N);
   localparam logic [MW-1:0] DEF = MW'(DEFAULT_MASTER);
   logic [N-1:0] split_mask, set_vec, eligible;
   logic [3:0] beat_cnt, beat_load;
   logic [MW-1:0] gnt_idx, win;
   logic split_set, fixed_burst, last_beat, arb_pt, hold, update;
   assign split_set = bus.hready && bus.hresp == 2'd3;
   assign set_vec = split_set ? N'(1) << bus.hmaster : '0;
   assign eligible = bus.hbusreq & ~(split_mask | set_vec);
   assign fixed_burst = bus.hburst[2:1] != 2'd0;
   assign beat_load = bus.hburst[2:1] == 2'd0 ? 4'd0 :
                      bus.hburst[2:1] == 2'd1 ? 4'd3 :
                      bus.hburst[2:1] == 2'd2 ? 4'd7 : 4'd15;
   assign last_beat = bus.htrans == 2'd3 && fixed_burst && beat_cnt == 4'd1;
   assign arb_pt = bus.hready && (bus.htrans == 2'd0 ||
                   (bus.htrans == 2'd2 && bus.hburst == 3'd0) || last_beat ||
                   (bus.htrans[1] && bus.hburst == 3'd1 && !bus.hbusreq[bus.hmaster]));
   // a SPLIT response overrides both lock retention and remaining beats
   assign hold = !split_set && bus.hlock[gnt_idx];
   assign update = (arb_pt || split_set) && !hold;
`ifdef AHB_ARB_FIXED_PRIO_EN
   always_comb begin
      win = DEF;
      for (int k = N - 1; k >= 0; k--)
         if (eligible[MW'(k)]) win = MW'(k);
   end
`else
   logic [MW-1:0] rr_ptr, j;
   logic found;
   always_comb begin
      win = DEF;
      found = 1'b0;
      j = '0;
      for (int k = N; k >= 1; k--) begin
         j = MW'((int'(rr_ptr) + k) % N);
         if (eligible[j]) begin
            win = j;
            found = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rr_ptr <= DEF;
      else if (update && found) rr_ptr <= win;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bus.hgrant <= N'(1) << DEF;
         gnt_idx <= DEF;
         bus.hmaster <= DEF;
         bus.hmastlock <= 1'b0;
         split_mask <= '0;
         beat_cnt <= '0;
      end else begin
         split_mask <= (split_mask & ~bus.hsplit) | set_vec;
         if (bus.hready && bus.htrans == 2'd2) beat_cnt <= beat_load;
         else if (bus.hready && bus.htrans == 2'd3 && beat_cnt != 4'd0) beat_cnt <= beat_cnt - 4'd1;
         if (update) begin
            gnt_idx <= win;
            bus.hgrant <= N'(1) << win;
         end
         if (bus.hready) begin
            bus.hmaster <= gnt_idx;
            bus.hmastlock <= bus.hlock[gnt_idx];
         end
      end
endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// tb_ahb_arbiter_rr: directed test-plan scenarios plus random bursty traffic,
// scored against a rule-level reference model of the arbiter.
module tb_ahb_arbiter_rr;
   localparam int N = 4;
   localparam int DEF = 0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   ahb_arbiter_rr_if #(.N(N)) bus();
   ahb_arbiter_rr #(.NO_OF_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int compared = 0;
   int mismatched = 0;
   logic [6:0] q[$];
   int gnt, mst, ptr, nlen, seqs;
   bit mlock;
   bit [N-1:0] mask;
   function automatic bit has(input bit [N-1:0] v, input int i);
      return ((v >> i) & N'(1)) != '0;
   endfunction
   function automatic int blen(input logic [2:0] b);
      return b < 3'd2 ? 1 : 4 << ((int'(b) - 2) / 2);
   endfunction
   task automatic model_reset;
      gnt = DEF; mst = DEF; ptr = DEF; mlock = 1'b0; mask = '0; nlen = 1; seqs = 0;
      q.delete();
   endtask
   // reference: apply the arbitration rules once per clock to the sampled inputs
   task automatic model_step;
      bit split, arb;
      bit [N-1:0] elig;
      int win, g0;
      g0 = gnt;
      split = bus.hready && bus.hresp == 2'd3;
      arb = bus.hready && (bus.htrans == 2'd0 || (bus.htrans == 2'd2 && bus.hburst == 3'd0) ||
            (bus.htrans == 2'd3 && bus.hburst >= 3'd2 && seqs == nlen - 2) ||
            (bus.htrans[1] && bus.hburst == 3'd1 && !has(bus.hbusreq, mst)));
      elig = bus.hbusreq & ~mask;
      if (split) elig = elig & ~(N'(1) << mst);
      if (split || (arb && !has(bus.hlock, g0))) begin
         win = DEF;
`ifdef AHB_ARB_FIXED_PRIO_EN
         for (int i = N - 1; i >= 0; i--) if (has(elig, i)) win = i;
`else
         for (int k = N; k >= 1; k--) if (has(elig, (ptr + k) % N)) win = (ptr + k) % N;
         if (elig != '0) ptr = win;
`endif
         gnt = win;
      end
      mask = mask & ~bus.hsplit;
      if (split) mask = mask | (N'(1) << mst);
      if (bus.hready && bus.htrans == 2'd2) begin
         nlen = blen(bus.hburst);
         seqs = 0;
      end else if (bus.hready && bus.htrans == 2'd3) seqs++;
      if (bus.hready) begin
         mst = g0;
         mlock = has(bus.hlock, g0);
      end
      q.push_back({N'(1) << gnt, 2'(mst), mlock});
   endtask
   always @(posedge clk or negedge rst_n)
      if (!rst_n) model_reset();
      else model_step();
   always @(negedge clk)
      if (rst_n && q.size() > 0) begin
         logic [6:0] e;
         e = q.pop_front();
         compared++;
         if ({bus.hgrant, bus.hmaster, bus.hmastlock} !== e) begin
            mismatched++;
            $display("FAIL scoreboard t=%0t got g=%b m=%0d l=%b expected g=%b m=%0d l=%b",
                     $time, bus.hgrant, bus.hmaster, bus.hmastlock, e[6:3], e[2:1], e[0]);
         end
      end
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic drive(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy, input logic [1:0] rs, input logic [3:0] sp);
      bus.hbusreq = req; bus.hlock = lck; bus.htrans = tr; bus.hburst = bu;
      bus.hready = rdy; bus.hresp = rs; bus.hsplit = sp;
      @(negedge clk);
   endtask
   initial begin
      int rem;
      bit stall;
      logic rdy;
      logic [1:0] tr;
      logic [2:0] bu;
      rem = 0; stall = 1'b0; tr = 2'd0; bu = 3'd0;
      bus.hbusreq = '0; bus.hlock = '0; bus.htrans = 2'd0; bus.hburst = 3'd0;
      bus.hready = 1'b1; bus.hresp = 2'd0; bus.hsplit = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_hgrant", 8'(bus.hgrant), 8'b0001);
      chk("reset_hmaster", 8'(bus.hmaster), 8'd0);
      chk("reset_hmastlock", 8'(bus.hmastlock), 8'd0);
      // masters 1 and 3 request, owner idles
      drive(4'b1010, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("rr_1", 8'(bus.hgrant), 8'b0010);
      drive(4'b1010, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
`ifdef AHB_ARB_FIXED_PRIO_EN
      chk("rr_2", 8'(bus.hgrant), 8'b0010);
`else
      chk("rr_2", 8'(bus.hgrant), 8'b1000);
`endif
      drive(4'b1010, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("rr_3", 8'(bus.hgrant), 8'b0010);
      // master 2 INCR4 with a wait state, master 0 waiting
      drive(4'b0100, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b0100, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("burst_owner", 8'(bus.hmaster), 8'd2);
      drive(4'b0101, 4'b0, 2'd2, 3'd3, 1'b1, 2'd0, 4'b0);
      drive(4'b0101, 4'b0, 2'd3, 3'd3, 1'b1, 2'd0, 4'b0);
      drive(4'b0101, 4'b0, 2'd3, 3'd3, 1'b0, 2'd0, 4'b0);
      chk("burst_wait", 8'(bus.hgrant), 8'b0100);
      drive(4'b0101, 4'b0, 2'd3, 3'd3, 1'b1, 2'd0, 4'b0);
      chk("burst_beat2", 8'(bus.hgrant), 8'b0100);
      drive(4'b0101, 4'b0, 2'd3, 3'd3, 1'b1, 2'd0, 4'b0);
      chk("burst_end_grant", 8'(bus.hgrant), 8'b0001);
      chk("burst_end_master", 8'(bus.hmaster), 8'd2);
      drive(4'b0001, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("burst_handover", 8'(bus.hmaster), 8'd0);
      // master 1 locked singles while master 2 requests
      drive(4'b0010, 4'b0010, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b0010, 4'b0010, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      repeat (3) begin
         drive(4'b0110, 4'b0010, 2'd2, 3'd0, 1'b1, 2'd0, 4'b0);
         chk("lock_grant", 8'(bus.hgrant), 8'b0010);
         chk("lock_mastlock", 8'(bus.hmastlock), 8'd1);
      end
      drive(4'b0100, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("lock_release", 8'(bus.hgrant), 8'b0100);
      // SPLIT on master 3, then HSPLIT release
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("split_owner", 8'(bus.hmaster), 8'd3);
      drive(4'b1000, 4'b0, 2'd2, 3'd0, 1'b1, 2'd3, 4'b0);
      chk("split_regrant", 8'(bus.hgrant), 8'b0001);
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("split_masked", 8'(bus.hgrant), 8'b0001);
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b1000);
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("split_cleared", 8'(bus.hgrant), 8'b1000);
      // nobody requests
      drive(4'b0, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b0, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("idle_grant", 8'(bus.hgrant), 8'b0001);
      chk("idle_master", 8'(bus.hmaster), 8'd0);
      // asynchronous reset in the middle of a locked WRAP8 with master 3 split
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b1000, 4'b0, 2'd2, 3'd0, 1'b1, 2'd3, 4'b0);
      drive(4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      drive(4'b0100, 4'b0100, 2'd2, 3'd4, 1'b1, 2'd0, 4'b0);
      drive(4'b0100, 4'b0100, 2'd3, 3'd4, 1'b1, 2'd0, 4'b0);
      drive(4'b0100, 4'b0100, 2'd3, 3'd4, 1'b1, 2'd0, 4'b0);
      chk("prereset_mastlock", 8'(bus.hmastlock), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_hgrant", 8'(bus.hgrant), 8'b0001);
      chk("async_hmaster", 8'(bus.hmaster), 8'd0);
      chk("async_hmastlock", 8'(bus.hmastlock), 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1000, 4'b0, 2'd0, 3'd0, 1'b1, 2'd0, 4'b0);
      chk("reset_clears_mask", 8'(bus.hgrant), 8'b1000);
      // random bursty traffic against the reference model
      repeat (3000) begin
         if (!stall) begin
            if (rem > 0) tr = ($urandom_range(0, 7) == 0) ? 2'd1 : 2'd3;
            else if ($urandom_range(0, 2) == 0) tr = 2'd0;
            else begin
               tr = 2'd2;
               bu = 3'($urandom_range(0, 7));
            end
         end
         rdy = $urandom_range(0, 3) != 0;
         drive(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0, tr, bu, rdy,
               ($urandom_range(0, 24) == 0) ? 2'd3 : 2'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0);
         stall = !rdy;
         if (rdy && tr == 2'd2) rem = (bu == 3'd1) ? int'($urandom_range(0, 4)) : blen(bu) - 1;
         else if (rdy && tr == 2'd3 && rem > 0) rem--;
      end
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
